arraymul_seq_ctrl: RTL and testbench



---
 rtl/arraymul_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_arraymul_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/arraymul_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier. A single 2x2 array cell is
// time-shared over every digit pair, and the shifted partial products are accumulated.

module arraymultiplier (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic a0b0, a1b0, a0b1, a1b1, c1;

  assign a0b0 = a[0] & b[0];
  assign a1b0 = a[1] & b[0];
  assign a0b1 = a[0] & b[1];
  assign a1b1 = a[1] & b[1];
  assign c1   = a1b0 & a0b1;
  assign p    = {a1b1 & c1, a1b1 ^ c1, a1b0 ^ a0b1, a0b0};
endmodule

module arraymul_seq_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2 * WIDTH;
  localparam logic [CW-1:0] NM1 = CW'(N - 1);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("arraymul_seq_ctrl: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [AW-1:0]    acc_q, acc_d, product_q, product_d;
  logic [CW-1:0]    i_q, i_d, j_q, j_d;
  logic [1:0]       dig_a, dig_b;
  logic [3:0]       pp;
  logic [CW+1:0]    sh;
  logic [AW-1:0]    pp_sh;
  logic             last;

  assign dig_a = 2'(ra_q >> {i_q, 1'b0});
  assign dig_b = 2'(rb_q >> {j_q, 1'b0});

  arraymultiplier u_cell (.a(dig_a), .b(dig_b), .p(pp));

  // Weight of digit pair (i,j) is 4^(i+j).
  assign sh    = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
  assign pp_sh = AW'(pp) << sh;
  assign last  = (i_q == NM1) && (j_q == NM1);

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    acc_d     = acc_q;
    product_d = product_q;
    i_d       = i_q;
    j_d       = j_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ra_d  = a;
          rb_d  = b;
          acc_d = '0;
          i_d   = '0;
          j_d   = '0;
          if (ZERO_SKIP && (a == '0 || b == '0)) begin
            product_d = '0;
            state_d   = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = acc_q + pp_sh;
        if (j_q == NM1) begin
          j_d = '0;
          i_d = (i_q == NM1) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        if (last) begin
          product_d = acc_d;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      acc_q     <= '0;
      product_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      i_q       <= i_d;
      j_q       <= j_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_arraymul_seq_ctrl.sv
// Scoreboard bench: three controllers (W8 skip, W8 no-skip, W4 skip) driven by
// directed operands; a monitor checks latency and product against queued expectations.

module tb_arraymul_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0] orm;
  logic [7:0] a [3];
  logic [7:0] b [3];
  logic [15:0] prod [3];
  logic [7:0] p4;
  logic       rand_mode, rnd;
  int         cyc = 0;
  int         n_chk = 0, n_pass = 0;
  int         acc_cyc [3];
  logic [2:0] prev_ov;

  typedef struct { int g; int p; int lat; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd <= ($urandom_range(0, 3) != 0);

  assign out_ready[1:0] = orm[1:0];
  assign out_ready[2]   = rand_mode ? rnd : orm[2];
  assign prod[2]        = {8'h00, p4};

  arraymul_seq_ctrl #(.WIDTH(8), .ZERO_SKIP(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .product(prod[0]), .busy(busy[0]));

  arraymul_seq_ctrl #(.WIDTH(8), .ZERO_SKIP(1'b0)) u_w8ns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .product(prod[1]), .busy(busy[1]));

  arraymul_seq_ctrl #(.WIDTH(4), .ZERO_SKIP(1'b1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2][3:0]), .b(b[2][3:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .product(p4), .busy(busy[2]));

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = '0;
      end else begin
        for (int g = 0; g < 3; g++) begin
          if (in_valid[g] && in_ready[g]) acc_cyc[g] = cyc;
          if (out_valid[g] && !prev_ov[g]) begin
            if (exp_q.size() == 0 || exp_q[0].g != g) begin
              n_chk++;
              $display("FAIL spurious_out dut%0d: out_valid=1 expected no output", g);
            end else begin
              chk($sformatf("latency dut%0d", g), 32'(cyc - acc_cyc[g]), 32'(exp_q[0].lat));
            end
          end
          if (out_valid[g] && out_ready[g] && exp_q.size() != 0 && exp_q[0].g == g) begin
            e = exp_q.pop_front();
            chk($sformatf("product dut%0d", g), 32'(prod[g]), 32'(e.p));
          end
          prev_ov[g] = out_valid[g];
        end
      end
    end
  endtask

  // Present operands until accepted, then queue the expected response.
  task automatic issue(input int g, input logic [7:0] av, input logic [7:0] bv,
                       input int ep, input int lat);
    int k;
    in_valid[g] = 1'b1;
    a[g] = av;
    b[g] = bv;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready[g] && k < 200);
    if (!in_ready[g]) begin
      n_chk++;
      $display("FAIL accept_timeout dut%0d: in_ready=0 expected 1", g);
    end else begin
      exp_q.push_back('{g, ep, lat});
    end
    @(posedge clk);
    #1 in_valid[g] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d outputs pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb, nv, k;
    rst_n = 1'b0;
    in_valid = '0;
    orm = 3'b111;
    rand_mode = 1'b0;
    prev_ov = '0;
    for (int g = 0; g < 3; g++) begin a[g] = '0; b[g] = '0; acc_cyc[g] = 0; end
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst out_valid dut%0d", g), 32'(out_valid[g]), 0);
      chk($sformatf("rst busy dut%0d", g), 32'(busy[g]), 0);
      chk($sformatf("rst product dut%0d", g), 32'(prod[g]), 0);
      chk($sformatf("rst in_ready dut%0d", g), 32'(in_ready[g]), 1);
    end
    @(posedge clk);
    #1;

    // Max operands: busy spans 17 cycles, out_valid exactly one.
    issue(0, 8'hFF, 8'hFF, 16'hFE01, 17);
    nb = 0; nv = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy[0]) nb++;
      if (out_valid[0]) nv++;
      if (!busy[0]) break;
    end
    chk("busy_cycles", 32'(nb), 17);
    chk("out_valid_cycles", 32'(nv), 1);
    drain();

    issue(0, 8'h00, 8'hA5, 0, 1);
    drain();
    issue(1, 8'h00, 8'hA5, 0, 17);
    drain();

    // Operand changes during RUN must not leak in.
    issue(0, 8'h0F, 8'h10, 16'h00F0, 17);
    repeat (3) @(posedge clk);
    #1 a[0] = 8'hFF; b[0] = 8'hFF;
    drain();

    // Backpressure with a competing input held during DONE.
    orm[0] = 1'b0;
    issue(0, 8'h12, 8'h34, 16'h03A8, 17);
    for (k = 0; k < 40 && !out_valid[0]; k++) @(negedge clk);
    if (!out_valid[0]) begin
      n_chk++;
      $display("FAIL bp_wait: out_valid=0 expected 1");
    end
    @(posedge clk);
    #1 in_valid[0] = 1'b1; a[0] = 8'h01; b[0] = 8'h02;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("bp product hold", 32'(prod[0]), 32'h03A8);
      chk("bp in_ready", 32'(in_ready[0]), 0);
      chk("bp out_valid", 32'(out_valid[0]), 1);
    end
    @(posedge clk);
    #1 orm[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp release out_valid", 32'(out_valid[0]), 0);
    chk("bp release in_ready", 32'(in_ready[0]), 1);
    exp_q.push_back('{0, 16'h0002, 17});
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    drain();

    // Reset in the middle of RUN abandons the operation.
    in_valid[0] = 1'b1; a[0] = 8'hFF; b[0] = 8'hFF;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready[0]) break;
    end
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", 32'(out_valid[0]), 0);
    chk("midrst busy", 32'(busy[0]), 0);
    chk("midrst product", 32'(prod[0]), 0);
    chk("midrst in_ready", 32'(in_ready[0]), 1);
    repeat (25) @(negedge clk);
    @(posedge clk);
    #1;
    issue(0, 8'h12, 8'h34, 16'h03A8, 17);
    drain();

    // WIDTH=4: every operand pair, random consumer stalls.
    rand_mode = 1'b1;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        issue(2, 8'(x), 8'(y), x * y, (x == 0 || y == 0) ? 1 : 5);
    drain();
    rand_mode = 1'b0;

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
